// File: rtl/register_file_pkg.sv
// register_file shared types: clear-engine states and the masked-OR helper
// used by both read ports.
package register_file_pkg;

  localparam int MAX_COUNT = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // One bit column of the file: OR of the values whose mask bit is set.
  function automatic logic mask_or(
    input logic [MAX_COUNT-1:0] values,
    input logic [MAX_COUNT-1:0] mask
  );
    return |(values & mask);
  endfunction

endpackage

// File: rtl/register_read_port.sv
// One read port: write-through bypass select, then the masked OR of the
// selected registers, plus the OR of their pending bits.
module register_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
) (
  input  logic [COUNT-1:0][WIDTH-1:0] values,
  input  logic                        wen,
  input  logic [COUNT-1:0]            wmask,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [COUNT-1:0]            pend,
  input  logic [COUNT-1:0]            mask,
  output logic [WIDTH-1:0]            bus,
  output logic                        busy
);

  logic [COUNT-1:0][WIDTH-1:0] eff;
  logic [MAX_COUNT-1:0]        col;
  logic [MAX_COUNT-1:0]        msk;

  always_comb begin
    eff = values;
    for (int i = 0; i < COUNT; i++) begin
      if (wen && wmask[i]) eff[i] = wdata;
    end
  end

  always_comb begin
    bus = '0;
    col = '0;
    msk = '0;
    msk[COUNT-1:0] = mask;
    for (int b = 0; b < WIDTH; b++) begin
      col = '0;
      for (int i = 0; i < COUNT; i++) begin
        col[i] = eff[i][b];
      end
      bus[b] = mask_or(col, msk);
    end
  end

  assign busy = |(pend & mask);

endmodule

// File: rtl/register_file.sv
// Parametrised register file: two masked read ports with bypass, a pending
// scoreboard and a one-register-per-cycle clear engine.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COUNT-1:0] o_regmask_a,
  output logic [WIDTH-1:0] o_bus_a,
  output logic             o_busy_a,
  input  logic [COUNT-1:0] o_regmask_b,
  output logic [WIDTH-1:0] o_bus_b,
  output logic             o_busy_b,
  input  logic [WIDTH-1:0] i_bus,
  input  logic [COUNT-1:0] i_regmask,
  input  logic             setter,
  input  logic [COUNT-1:0] reserve_mask,
  input  logic             reserve,
  input  logic             clear_req,
  output logic             clear_busy
);

  localparam int IW = $clog2(COUNT);
  localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

  logic [COUNT-1:0][WIDTH-1:0] regs;
  logic [COUNT-1:0]            pend;
  state_t                      state;
  logic [IW-1:0]               idx;
  logic                        wen;

  assign clear_busy = (state == SWEEP);
  assign wen        = setter && !clear_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      pend  <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          for (int i = 0; i < COUNT; i++) begin
            if (setter && i_regmask[i]) regs[i] <= i_bus;
            // reserve beats a same-cycle write on the pending bit
            if (reserve && reserve_mask[i])
              pend[i] <= 1'b1;
            else if (setter && i_regmask[i])
              pend[i] <= 1'b0;
          end
          if (clear_req) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          for (int i = 0; i < COUNT; i++) begin
            if (idx == IW'(i)) begin
              regs[i] <= '0;
              pend[i] <= 1'b0;
            end
          end
          if (idx == LAST)
            state <= IDLE;
          else
            idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  register_read_port #(
    .WIDTH(WIDTH),
    .COUNT(COUNT)
  ) u_port_a (
    .values(regs),
    .wen   (wen),
    .wmask (i_regmask),
    .wdata (i_bus),
    .pend  (pend),
    .mask  (o_regmask_a),
    .bus   (o_bus_a),
    .busy  (o_busy_a)
  );

  register_read_port #(
    .WIDTH(WIDTH),
    .COUNT(COUNT)
  ) u_port_b (
    .values(regs),
    .wen   (wen),
    .wmask (i_regmask),
    .wdata (i_bus),
    .pend  (pend),
    .mask  (o_regmask_b),
    .bus   (o_bus_b),
    .busy  (o_busy_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus random traffic checked
// against an array-based reference model.
module tb_register_file;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int W5 = 16;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] mask_a, mask_b, wmask, rmask;
  logic [W-1:0] wdata, bus_a, bus_b;
  logic setter, reserve, clear_req;
  logic busy_a, busy_b, cbusy;

  logic [N5-1:0] mask5, wmask5, rmask5;
  logic [W5-1:0] wdata5, bus_a5, bus_b5;
  logic setter5, reserve5, clear_req5;
  logic busy_a5, busy_b5, cbusy5;

  int vectors = 0;
  int errors  = 0;

  register_file #(.WIDTH(W), .COUNT(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_regmask_a(mask_a), .o_bus_a(bus_a), .o_busy_a(busy_a),
    .o_regmask_b(mask_b), .o_bus_b(bus_b), .o_busy_b(busy_b),
    .i_bus(wdata), .i_regmask(wmask), .setter(setter),
    .reserve_mask(rmask), .reserve(reserve),
    .clear_req(clear_req), .clear_busy(cbusy)
  );

  register_file #(.WIDTH(W5), .COUNT(N5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .o_regmask_a(mask5), .o_bus_a(bus_a5), .o_busy_a(busy_a5),
    .o_regmask_b(mask5), .o_bus_b(bus_b5), .o_busy_b(busy_b5),
    .i_bus(wdata5), .i_regmask(wmask5), .setter(setter5),
    .reserve_mask(rmask5), .reserve(reserve5),
    .clear_req(clear_req5), .clear_busy(cbusy5)
  );

  // reference model of the 8x8 instance
  logic [W-1:0] mreg [N];
  bit           mpend[N];
  bit           msw;
  int           mpos;

  function automatic logic [W-1:0] exp_bus(input logic [N-1:0] m);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (m[i])
        r |= (setter && wmask[i] && !msw) ? wdata : mreg[i];
    return r;
  endfunction

  function automatic logic exp_busy(input logic [N-1:0] m);
    logic r = 1'b0;
    for (int i = 0; i < N; i++)
      if (m[i] && mpend[i]) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
    msw  = 1'b0;
    mpos = 0;
  endtask

  task automatic idle_in();
    setter = 0; reserve = 0; clear_req = 0;
    wmask = '0; rmask = '0; wdata = '0;
    setter5 = 0; reserve5 = 0; clear_req5 = 0;
    wmask5 = '0; rmask5 = '0; wdata5 = '0;
  endtask

  // one clock edge; the model follows the inputs held across it
  task automatic tick();
    @(posedge clk);
    if (!msw) begin
      for (int i = 0; i < N; i++) begin
        if (reserve && rmask[i]) mpend[i] = 1'b1;
        else if (setter && wmask[i]) mpend[i] = 1'b0;
        if (setter && wmask[i]) mreg[i] = wdata;
      end
      if (clear_req) begin
        msw  = 1'b1;
        mpos = 0;
      end
    end else begin
      mreg[mpos]  = '0;
      mpend[mpos] = 1'b0;
      mpos++;
      if (mpos == N) msw = 1'b0;
    end
    #1;
  endtask

  task automatic write_reg(input int r, input logic [W-1:0] d);
    setter = 1; wmask = N'(1) << r; wdata = d;
    tick();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    mask_a = 8'hFF; mask_b = 8'h5A;
    rst_n = 0;
    model_reset();
    #2;
    vectors++;
    if (bus_a !== '0 || bus_b !== '0) begin
      errors++;
      $display("FAIL reset_bus a=%h b=%h want 0", bus_a, bus_b);
    end
    vectors++;
    if (busy_a !== 0 || busy_b !== 0 || cbusy !== 0) begin
      errors++;
      $display("FAIL reset_flags %b%b%b want 000", busy_a, busy_b, cbusy);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    write_reg(2, 8'h3C);
    write_reg(5, 8'hC1);
    mask_a = 8'h04; mask_b = 8'h24;
    #1;
    vectors++;
    if (bus_a !== 8'h3C) begin
      errors++;
      $display("FAIL wr_read_a got %h want 3c", bus_a);
    end
    vectors++;
    if (bus_b !== 8'hFD) begin
      errors++;
      $display("FAIL wr_read_b got %h want fd", bus_b);
    end
  endtask

  task automatic test_bypass();
    write_reg(1, 8'h11);
    setter = 1; wmask = 8'h02; wdata = 8'hAA; mask_a = 8'h02;
    #1;
    vectors++;
    if (bus_a !== 8'hAA) begin
      errors++;
      $display("FAIL bypass_same got %h want aa", bus_a);
    end
    tick();
    idle_in();
    #1;
    vectors++;
    if (bus_a !== 8'hAA) begin
      errors++;
      $display("FAIL bypass_after got %h want aa", bus_a);
    end
  endtask

  task automatic test_scoreboard();
    mask_a = 8'h08;
    reserve = 1; rmask = 8'h08;
    tick();
    idle_in();
    vectors++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL sb_reserve got %b want 1", busy_a);
    end
    setter = 1; wmask = 8'h08; wdata = 8'h77;
    #1;
    vectors++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL sb_no_comb_clear got %b want 1", busy_a);
    end
    tick();
    idle_in();
    vectors++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL sb_write_clear got %b want 0", busy_a);
    end
    reserve = 1; rmask = 8'h08;
    setter = 1; wmask = 8'h08; wdata = 8'h99;
    tick();
    idle_in();
    vectors++;
    if (busy_a !== 1'b1 || bus_a !== 8'h99) begin
      errors++;
      $display("FAIL sb_both got %b/%h want 1/99", busy_a, bus_a);
    end
    write_reg(3, 8'h42);
  endtask

  task automatic test_clear();
    int n = 0;
    setter = 1; wmask = 8'hFF; wdata = 8'hFF;
    tick();
    idle_in();
    clear_req = 1;
    tick();
    clear_req = 0;
    while (cbusy === 1'b1 && n < 20) begin
      mask_a = 8'hFF; mask_b = N'(1) << (n % N);
      if (n == 2) begin
        setter = 1; wmask = 8'h80; wdata = 8'h55;
        reserve = 1; rmask = 8'h80;
      end
      #1;
      vectors++;
      if (bus_a !== exp_bus(mask_a) || bus_b !== exp_bus(mask_b)) begin
        errors++;
        $display("FAIL sweep_read n=%0d got %h/%h want %h/%h",
                 n, bus_a, bus_b, exp_bus(mask_a), exp_bus(mask_b));
      end
      tick();
      idle_in();
      n++;
    end
    vectors++;
    if (n !== N) begin
      errors++;
      $display("FAIL sweep_len got %0d want %0d", n, N);
    end
    mask_a = 8'h80;
    #1;
    vectors++;
    if (bus_a !== 8'h00 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL sweep_drop got %h/%b want 00/0", bus_a, busy_a);
    end
    write_reg(7, 8'h5A);
    vectors++;
    if (bus_a !== 8'h5A) begin
      errors++;
      $display("FAIL post_sweep_wr got %h want 5a", bus_a);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      mask_a  = N'($urandom);
      mask_b  = N'($urandom);
      setter  = ($urandom_range(0, 1) == 1);
      wmask   = N'($urandom);
      wdata   = W'($urandom);
      reserve = ($urandom_range(0, 3) == 0);
      rmask   = N'($urandom);
      clear_req = ($urandom_range(0, 30) == 0);
      #1;
      vectors++;
      if (bus_a !== exp_bus(mask_a) || bus_b !== exp_bus(mask_b)) begin
        errors++;
        $display("FAIL rand_bus k=%0d got %h/%h want %h/%h",
                 k, bus_a, bus_b, exp_bus(mask_a), exp_bus(mask_b));
      end
      vectors++;
      if (busy_a !== exp_busy(mask_a) || busy_b !== exp_busy(mask_b)
          || cbusy !== msw) begin
        errors++;
        $display("FAIL rand_flags k=%0d got %b%b%b want %b%b%b", k,
                 busy_a, busy_b, cbusy,
                 exp_busy(mask_a), exp_busy(mask_b), msw);
      end
      tick();
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    setter = 1; wmask = 8'hFF; wdata = 8'hFF;
    tick();
    idle_in();
    clear_req = 1;
    tick();
    clear_req = 0;
    tick(); tick(); tick();
    rst_n = 0;
    model_reset();
    mask_a = 8'hFF; mask_b = 8'hFF;
    #1;
    vectors++;
    if (cbusy !== 1'b0 || bus_a !== 8'h00 || bus_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got %b/%h/%h want 0/00/00",
               cbusy, bus_a, bus_b);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_count5();
    int n = 0;
    mask5 = 5'h1F;
    setter5 = 1; wmask5 = 5'h1F; wdata5 = 16'hBEEF;
    tick();
    idle_in();
    #1;
    vectors++;
    if (bus_a5 !== 16'hBEEF) begin
      errors++;
      $display("FAIL c5_load got %h want beef", bus_a5);
    end
    clear_req5 = 1;
    tick();
    clear_req5 = 0;
    while (cbusy5 === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== N5 || bus_a5 !== 16'h0) begin
      errors++;
      $display("FAIL c5_sweep got %0d/%h want %0d/0000", n, bus_a5, N5);
    end
  endtask

  initial begin
    idle_in();
    mask_a = '0; mask_b = '0; mask5 = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_random();
    test_reset_mid();
    test_count5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised, reset-able successor to the 8×8 one-hot-addressed register bank. It provides COUNT registers of WIDTH bits with two one-hot/multi-hot read ports, one multi-hot write port, and write-through bypass. It adds a per-register pending scoreboard for in-flight results and a sequential clear engine that zeroes the file one register per cycle. It sits between the decoder/ALU datapath and the writeback bus, and is the drop-in target for all cores of the next generation.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits (≥1)
- COUNT, 8, number of registers (≥2); all masks are COUNT bits, bit i selects register i

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- o_regmask_a  in  COUNT  read-port A select mask
- o_bus_a  out  WIDTH  read-port A data
- o_busy_a  out  1  any register selected on A is pending
- o_regmask_b  in  COUNT  read-port B select mask
- o_bus_b  out  WIDTH  read-port B data
- o_busy_b  out  1  any register selected on B is pending
- i_bus  in  WIDTH  write data
- i_regmask  in  COUNT  write select mask
- setter  in  1  write strobe
- reserve_mask  in  COUNT  registers to mark pending
- reserve  in  1  reserve strobe
- clear_req  in  1  start sequential clear
- clear_busy  out  1  clear engine active; writes and reserves are dropped

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Read (combinational): eff_i = (setter && i_regmask[i] && !clear_busy) ? i_bus : reg_i; o_bus_x = bitwise OR of eff_i over set bits of the mask; all-zero mask gives 0. Multi-hot masks OR values, as in the legacy bank.
- Write: on a clk edge with setter=1 and the FSM in IDLE, every reg_i with i_regmask[i]=1 takes i_bus.
- Scoreboard: pend_i is set on an edge with reserve=1 && reserve_mask[i] in IDLE, and cleared on an accepted write to i. If reserve and write hit the same i in one cycle, reserve wins (pend_i=1, reg_i=i_bus).
- o_busy_x = OR of pend_i over the mask. It reflects registered pend only; a same-cycle write does not clear busy combinationally.
- Clear FSM, states IDLE and SWEEP, index counter idx of width $clog2(COUNT):
  - IDLE → SWEEP on clear_req=1, with idx←0.
  - In SWEEP, each edge sets reg_idx←0 and pend_idx←0, then idx++.
  - When idx=COUNT-1 is cleared, the FSM returns to IDLE; idx does not wrap.
  - clear_busy = (state==SWEEP).
  - clear_req in SWEEP is ignored; there is no restart.
  - setter and reserve in SWEEP are discarded, with no bypass.
  - Reads in SWEEP return current contents: swept registers read 0, unswept ones keep their old values.
- Reset (rst_n=0, async): all reg_i=0, all pend_i=0, state=IDLE, idx=0. A reset mid-sweep aborts the sweep immediately.

## Timing
- Read latency 0 (combinational from masks, registers and the bypass path).
- Write latency 1 edge; bypass makes the data visible on read ports in the same cycle.
- Scoreboard set/clear takes effect 1 edge after the strobe.
- Clear takes exactly COUNT edges after the edge that samples clear_req. clear_busy rises 1 edge after clear_req and falls on the edge that clears register COUNT-1. A write in the cycle after clear_busy falls is accepted.
- Outputs during and after reset: o_bus_a/b=0, o_busy_a/b=0, clear_busy=0.

## Structure
- Package register_file_pkg holds the state enum (IDLE, SWEEP) and a function mask_or(values, mask).
- Sub-module register_read_port (parametrised WIDTH, COUNT) implements bypass-select plus the masked OR; it is instantiated twice (A, B) and shares the bypass inputs.
- Storage, scoreboard and clear FSM live in the top module.

## Test plan
- Reset and read: with rst_n pulsed low, any masks → o_bus_a=o_bus_b=0, busy=0.
- Write and dual read: WIDTH=8, COUNT=8. Write 0x3C to r2 and 0xC1 to r5, then mask_a=0x04 and mask_b=0x24 → o_bus_a=0x3C, o_bus_b=0xFD.
- Bypass: r1=0x11, then setter with i_regmask=0x02, i_bus=0xAA and mask_a=0x02 → o_bus_a=0xAA in the same cycle, r1=0xAA after the edge.
- Scoreboard: reserve 0x08 → next cycle o_busy_a=1 for mask 0x08; write r3 → busy=0 next cycle. Reserve and write r3 in the same cycle → busy stays 1.
- Clear: load all registers with 0xFF and pulse clear_req → clear_busy is high for exactly 8 cycles and r0..r7 read 0 progressively. A write to r7 at sweep cycle 2 is dropped and r7 ends at 0. After completion, r7 is writable again.
- Reset mid-sweep: assert rst_n low at sweep cycle 3 → clear_busy=0 immediately and all registers read 0. With COUNT=5, WIDTH=16, the sweep lasts 5 cycles.
